// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and operand-signedness helpers for the RV32M multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_signed_a(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the EX stage (master) and the muldiv unit (slave)
//   i_valid/o_ready  request handshake, i_op funct3, i_op_a/i_op_b operands
//   i_flush          kills the in-flight op
//   o_valid/o_result one-cycle result strobe and result
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            i_flush;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_valid, i_op, i_op_a, i_op_b, i_flush,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_op, i_op_a, i_op_b, i_flush,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide unit (XLEN steps per op)
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      muldiv_if slave: request handshake in, result strobe out
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    state_e            r_state;
    op_e               r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;

    op_e             w_op;
    logic            w_accept;
    logic            w_sa;
    logic            w_sb;
    logic            w_bzero;
    logic            w_special;
    logic            w_sel_hi;
    logic            w_finish;
    logic            w_cin;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_spec_hi;
    logic [XLEN-1:0] w_spec_lo;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_sel;
    logic [XLEN:0]   w_x;
    logic [XLEN:0]   w_y;
    logic [XLEN+1:0] w_sum;

    assign w_op     = op_e'(bus.i_op);
    assign w_accept = (r_state == IDLE) && bus.i_valid && !bus.i_flush;
    assign w_sa     = is_signed_a(w_op) && bus.i_op_a[XLEN-1];
    assign w_sb     = is_signed_b(w_op) && bus.i_op_b[XLEN-1];
    assign w_abs_a  = w_sa ? -bus.i_op_a : bus.i_op_a;
    assign w_abs_b  = w_sb ? -bus.i_op_b : bus.i_op_b;

    // Divide by zero and signed overflow skip CALC; their {rem, quo} is loaded straight into r_acc.
    assign w_bzero   = bus.i_op_b == '0;
    assign w_special = w_op[2] && (w_bzero || (!w_op[0] && bus.i_op_a == {1'b1, {(XLEN-1){1'b0}}}
                       && bus.i_op_b == '1));
    assign w_spec_hi = w_bzero ? bus.i_op_a : {XLEN{1'b0}};
    assign w_spec_lo = w_bzero ? {XLEN{1'b1}} : bus.i_op_a;

    // r_acc is {product_hi, product_lo/multiplier} for multiply and {remainder, quotient} for divide.
    assign w_hi     = r_acc[2*XLEN-1:XLEN];
    assign w_lo     = r_acc[XLEN-1:0];
    assign w_sel_hi = r_op[2] ? r_op[1] : (r_op[1:0] != 2'b00);
    assign w_sel    = w_sel_hi ? w_hi : w_lo;

    // Shared adder. CALC: shift-add or trial subtract (carry out = no borrow).
    // DONE: two's-complement negate of the selected half; the high half of a negated
    // product only takes the +1 when the low half is zero.
    assign w_x   = (r_state == CALC) ? (r_op[2] ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi})
                                     : {1'b0, r_neg ? ~w_sel : w_sel};
    assign w_y   = (r_state != CALC) ? '0 : r_op[2] ? ~{1'b0, r_opnd} : r_acc[0] ? {1'b0, r_opnd} : '0;
    assign w_cin = (r_state == CALC) ? r_op[2] : r_neg && (r_op[2] || !w_sel_hi || w_lo == '0);
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(XLEN+1){1'b0}}, w_cin};

    assign w_finish     = (r_state == DONE) && !bus.i_flush;
    assign bus.o_ready  = r_state == IDLE;
    assign bus.o_valid  = w_finish;
    assign bus.o_result = w_finish ? w_sum[XLEN-1:0] : r_result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= w_op;
                    r_cnt   <= '0;
                    r_state <= w_special ? DONE : CALC;
                    r_neg   <= w_special ? 1'b0 : (w_op[2] && w_op[1]) ? w_sa : w_sa ^ w_sb;
                    r_opnd  <= w_op[2] ? w_abs_b : w_abs_a;
                    r_acc   <= w_special ? {w_spec_hi, w_spec_lo}
                                         : {{XLEN{1'b0}}, w_op[2] ? w_abs_a : w_abs_b};
                end
                CALC: if (bus.i_flush) begin
                    r_state <= IDLE;
                end else begin
                    r_acc   <= r_op[2] ? {w_sum[XLEN+1] ? w_sum[XLEN-1:0] : w_x[XLEN-1:0],
                                          w_lo[XLEN-2:0], w_sum[XLEN+1]}
                                       : {w_sum[XLEN:0], w_lo[XLEN-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == CNT_W'(XLEN-1)) ? DONE : CALC;
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_result <= w_finish ? w_sum[XLEN-1:0] : r_result;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
